wb_icu186: RTL
==============

# wb_icu186

Interrupt control unit for the 80186 co-processor. It is a Wishbone slave in the interrupt-control I/O window, 0xFF20–0xFF3E, which is currently stubbed on switch slave 2. It latches and prioritises five interrupt sources and drives the CPU `intr` line. On `inta` it supplies the vector, replacing the constant 0x0C vector and the ad-hoc tube-interrupt edge latch in the top level. It tracks in-service state and end-of-interrupt (EOI) so that nested interrupts follow 80186 master-mode rules.

## Interface
Parameters:
- `SPUR_VEC`, default 8'h07: vector returned when `inta` rises with no eligible request.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each: Wishbone cycle, strobe and write enable.
- `wb_adr_i`  in  [4:1]: word offset from 0xFF20.
- `wb_sel_i`  in  [1:0]: byte lanes; a write updates only the selected bytes.
- `wb_dat_i`  in  16: write data.
- `wb_dat_o`  out  16: read data.
- `wb_ack_o`  out  1: registered acknowledge.
- `irq_i`  in  [4:0]: asynchronous sources. Bit 0 is TMR (type 8); bits 1–4 are INT0–INT3 (types 12–15). Bit 1 is the tube IRQ, already inverted.
- `intr_o`  out  1: interrupt request to the CPU (`wb_tgc_i`).
- `inta_i`  in  1: acknowledge from the CPU (`wb_tgc_o`); held high for the whole acknowledge.
- `vec_o`  out  8: vector, muxed onto CPU read data while `inta_i` is high.

## Operation
Register map (`adr` = `wb_adr_i`):
- `adr` 1, EOI (W): bit [15] is NSPEC, bits [4:0] are the type.
  - NSPEC=1 clears the highest-priority in-service bit.
  - NSPEC=0 clears the bit for the given type; an unknown type has no effect.
- `adr` 2, POLL (R): bit [15] = request pending, bits [4:0] = winning type. The read has the same side effects as an `inta` edge.
- `adr` 3, POLLSTS (R): same data as POLL, with no side effects.
- `adr` 4, MASK (RW): bits [4:0] are the per-source mask bits, aliased to each source's control bit [3].
- `adr` 5, PRIMSK (RW): bits [2:0]; reset value 7.
- `adr` 6, INSERV (RW): bits [4:0].
- `adr` 7, REQST (R): bits [4:0].
- `adr` 9, TCUCON, and `adr` 12–15, I0CON–I3CON (RW):
  - bits [2:0] PR: priority, 0 is highest.
  - bit [3] MSK: mask.
  - bit [4] LTM: 1 = level-triggered, 0 = edge-triggered.
  - Reset value 0x000F. Bits [15:5] read as 0.
- Any other offset reads 0; writes to it are ignored.

Request capture:
- Each `irq_i` bit passes through a 2-FF synchroniser plus a delay FF.
- Edge mode: a synchronised rising edge sets REQST; REQST is cleared by acknowledge or POLL.
- Level mode: REQST equals the synchronised level.

Arbitration (evaluated every cycle):
- A source is eligible if REQST=1, MSK=0, PR ≤ PRIMSK, and PR is strictly less than the minimum PR among in-service sources (8 if none are in service).
- The winner is the eligible source with the lowest PR. Equal PR is broken in the fixed order TMR, INT0, INT1, INT2, INT3.
- `intr_o` is registered: `intr_o` = (a winner exists) and not (an `inta` edge this cycle).

Acknowledge:
- On an `inta_i` rising edge (`inta_i` high and the registered `inta_i` low):
  - latch the winner's vector into `vec_o`;
  - set its INSERV bit;
  - clear its REQST bit if it is edge-triggered.
- If there is no winner: `vec_o` = `SPUR_VEC` and no state changes.
- `vec_o` holds until the next `inta` edge.

Simultaneous events:
- EOI clear and acknowledge set in the same cycle: clear is applied first, then set. If both target the same bit, set wins.
- A new edge arriving in the same cycle as an acknowledge clear of that source: set wins, so the request is not lost.
- A register write and a hardware update to the same bit in the same cycle: the hardware update wins.

Reset:
- All outputs go to 0: `intr_o`, `wb_ack_o`, `wb_dat_o`, `vec_o`.
- REQST and INSERV are cleared; synchronisers are cleared.
- PRIMSK = 7; all control registers = 0x000F (all sources masked).
- Reset asserted mid-cycle aborts any pending acknowledge.

## Timing
- Wishbone:
  - `wb_ack_o` goes high for exactly one cycle, in the cycle after `cyc & stb & ~ack`.
  - The write takes effect at that acknowledging edge.
  - Read data is valid while `wb_ack_o` is high.
  - Back-to-back accesses therefore acknowledge every other cycle.
- Request latency: if `irq_i` is first sampled high at edge N, REQST is set at edge N+2 and `intr_o` is high after edge N+3.
- `intr_o` falls at the edge following the `inta` edge.
- `vec_o` is valid from the edge following the `inta` rise.
- EOI or mask changes are reflected on `intr_o` one cycle after the write's acknowledge.

## Structure
- Package `icu186_pkg` holds:
  - register offset constants;
  - source index constants;
  - the type table {8, 12, 13, 14, 15};
  - control-register reset value 0x000F and PRIMSK reset value 7;
  - the control-register field positions (PR, MSK, LTM).
- Sub-module `icu186_resolve` is purely combinational. Inputs: REQST, masks, PRs, PRIMSK, INSERV. Outputs: winner valid, winner index, highest in-service index.

## Test plan
- Reset; write I0CON=0x0002; pulse `irq_i[1]` -> `intr_o` high 3 cycles after sampling; `inta` rise -> `vec_o`=0x0C, INSERV=0x02, REQST=0.
- TMR at PR=1 and INT2 at PR=1 requested together -> `vec_o`=0x08 first; INT2 (0x0E) is acknowledged only after EOI 0x8000.
- INT1 in service (PR=3), then INT0 requests at PR=5 -> `intr_o` stays 0; EOI type 13 -> `intr_o` rises.
- INT3 in level mode, PR=0, PRIMSK=0 -> `intr_o` follows the level; setting PRIMSK below PR is not possible, so set MSK instead -> `intr_o` drops the cycle after the write's acknowledge.
- `inta` rise with no requests -> `vec_o`=0x07, INSERV unchanged; POLLSTS reads 0x0000.
- `reset_n` asserted low during an `inta` high period -> all outputs 0 immediately, control registers read 0x000F.

Source files
------------

// File: rtl/icu186_pkg.sv
// rtl/icu186_pkg.sv - shared constants, type table and helpers for the 80186 interrupt control unit
package icu186_pkg;

    localparam int NSRC  = 5;
    localparam int CTL_W = 5;

    // Word offsets from 0xFF20 (wb_adr_i[4:1])
    localparam logic [3:0] ADR_EOI     = 4'd1;
    localparam logic [3:0] ADR_POLL    = 4'd2;
    localparam logic [3:0] ADR_POLLSTS = 4'd3;
    localparam logic [3:0] ADR_MASK    = 4'd4;
    localparam logic [3:0] ADR_PRIMSK  = 4'd5;
    localparam logic [3:0] ADR_INSERV  = 4'd6;
    localparam logic [3:0] ADR_REQST   = 4'd7;
    localparam logic [3:0] ADR_TCUCON  = 4'd9;
    localparam logic [3:0] ADR_I0CON   = 4'd12;
    localparam logic [3:0] ADR_I1CON   = 4'd13;
    localparam logic [3:0] ADR_I2CON   = 4'd14;
    localparam logic [3:0] ADR_I3CON   = 4'd15;

    // Source indices; the index order is also the tie-break order
    localparam int SRC_TMR  = 0;
    localparam int SRC_INT0 = 1;
    localparam int SRC_INT1 = 2;
    localparam int SRC_INT2 = 3;
    localparam int SRC_INT3 = 4;

    // Interrupt type per source, entry 0 is TMR
    localparam logic [NSRC-1:0][4:0] SRC_TYPE = {5'd15, 5'd14, 5'd13, 5'd12, 5'd8};

    localparam logic [CTL_W-1:0] CTL_RST    = 5'h0F;
    localparam logic [2:0]       PRIMSK_RST = 3'd7;

    // Control register fields
    localparam int CTL_PR_LSB = 0;
    localparam int CTL_PR_MSB = 2;
    localparam int CTL_MSK    = 3;
    localparam int CTL_LTM    = 4;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } src_sel_t;

    // Map an interrupt type back to its source; unknown types are not valid
    function automatic src_sel_t type_src(input logic [4:0] t);
        src_sel_t r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (SRC_TYPE[i] == t) begin
                r.vld = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icu186_resolve.sv
// rtl/icu186_resolve.sv - combinational priority resolver for pending and in-service sources
module icu186_resolve
    import icu186_pkg::*;
(
    input  logic [NSRC-1:0]       reqst_i,
    input  logic [NSRC-1:0]       msk_i,
    input  logic [NSRC-1:0][2:0]  pr_i,
    input  logic [2:0]            primsk_i,
    input  logic [NSRC-1:0]       inserv_i,
    output logic                  win_vld_o,
    output logic [2:0]            win_idx_o,
    output logic                  isr_vld_o,
    output logic [2:0]            isr_idx_o
);

    logic [3:0]      isr_pr;
    logic [3:0]      win_pr;
    logic [NSRC-1:0] elig;

    // Highest-priority in-service source; 8 means nothing is in service
    always_comb begin
        isr_pr    = 4'd8;
        isr_vld_o = 1'b0;
        isr_idx_o = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (inserv_i[i] && ({1'b0, pr_i[i]} < isr_pr)) begin
                isr_pr    = {1'b0, pr_i[i]};
                isr_vld_o = 1'b1;
                isr_idx_o = 3'(i);
            end
        end
    end

    // Lowest-PR eligible request wins; strict compare keeps the lower index on ties
    always_comb begin
        win_pr    = 4'd8;
        win_vld_o = 1'b0;
        win_idx_o = '0;
        elig      = '0;
        for (int i = 0; i < NSRC; i++) begin
            elig[i] = reqst_i[i] & ~msk_i[i] & (pr_i[i] <= primsk_i)
                    & ({1'b0, pr_i[i]} < isr_pr);
            if (elig[i] && ({1'b0, pr_i[i]} < win_pr)) begin
                win_pr    = {1'b0, pr_i[i]};
                win_vld_o = 1'b1;
                win_idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/wb_icu186.sv
// rtl/wb_icu186.sv - Wishbone interrupt control unit for the 80186 co-processor
module wb_icu186
    import icu186_pkg::*;
#(
    parameter logic [7:0] SPUR_VEC = 8'h07
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:1]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [4:0]  irq_i,
    output logic        intr_o,
    input  logic        inta_i,
    output logic [7:0]  vec_o
);

    logic [NSRC-1:0]            sync1_q, sync2_q, dly_q;
    logic [NSRC-1:0]            reqst_q, reqst_d;
    logic [NSRC-1:0]            inserv_q, inserv_d;
    logic [NSRC-1:0][CTL_W-1:0] ctl_q, ctl_d;
    logic [2:0]                 primsk_q, primsk_d;
    logic                       inta_q;
    logic                       intr_q, intr_d;
    logic                       ack_q, ack_d;
    logic [15:0]                dat_q, dat_d;
    logic [7:0]                 vec_q, vec_d;

    logic [NSRC-1:0]            msk, ltm, rise;
    logic [NSRC-1:0][2:0]       pr;
    logic                       win_vld, isr_vld;
    logic [2:0]                 win_idx, isr_idx;
    logic [4:0]                 win_type;
    logic                       wb_req, wr, lo_wr, rd, inta_edge, poll_rd, take;
    logic [15:0]                wdat, rdata, poll_word;
    logic                       ctl_hit;
    logic [2:0]                 ctl_idx;
    src_sel_t                   eoi_sel;
    logic                       unused_bits;

    // Split control registers into their fields
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pr[i]  = ctl_q[i][CTL_PR_MSB:CTL_PR_LSB];
            msk[i] = ctl_q[i][CTL_MSK];
            ltm[i] = ctl_q[i][CTL_LTM];
        end
    end

    icu186_resolve u_resolve (
        .reqst_i   (reqst_q),
        .msk_i     (msk),
        .pr_i      (pr),
        .primsk_i  (primsk_q),
        .inserv_i  (inserv_q),
        .win_vld_o (win_vld),
        .win_idx_o (win_idx),
        .isr_vld_o (isr_vld),
        .isr_idx_o (isr_idx)
    );

    assign win_type    = SRC_TYPE[win_idx];
    assign rise        = sync2_q & ~dly_q;
    assign wb_req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr          = wb_req & wb_we_i;
    assign lo_wr       = wr & wb_sel_i[0];
    assign rd          = wb_req & ~wb_we_i;
    assign wdat        = {wb_sel_i[1] ? wb_dat_i[15:8] : 8'h00,
                          wb_sel_i[0] ? wb_dat_i[7:0]  : 8'h00};
    assign inta_edge   = inta_i & ~inta_q;
    assign poll_rd     = rd & (wb_adr_i == ADR_POLL);
    assign take        = (inta_edge | poll_rd) & win_vld;
    assign poll_word   = win_vld ? {1'b1, 10'b0, win_type} : 16'h0000;
    assign unused_bits = ^wdat[14:5];

    // Decode the per-source control register offsets
    always_comb begin
        ctl_hit = 1'b1;
        ctl_idx = '0;
        case (wb_adr_i)
            ADR_TCUCON: ctl_idx = 3'(SRC_TMR);
            ADR_I0CON:  ctl_idx = 3'(SRC_INT0);
            ADR_I1CON:  ctl_idx = 3'(SRC_INT1);
            ADR_I2CON:  ctl_idx = 3'(SRC_INT2);
            ADR_I3CON:  ctl_idx = 3'(SRC_INT3);
            default:    ctl_hit = 1'b0;
        endcase
    end

    // Read data multiplexer
    always_comb begin
        rdata = 16'h0000;
        case (wb_adr_i)
            ADR_POLL, ADR_POLLSTS: rdata = poll_word;
            ADR_MASK:   rdata = {11'b0, msk};
            ADR_PRIMSK: rdata = {13'b0, primsk_q};
            ADR_INSERV: rdata = {11'b0, inserv_q};
            ADR_REQST:  rdata = {11'b0, reqst_q};
            default:    rdata = ctl_hit ? {11'b0, ctl_q[ctl_idx]} : 16'h0000;
        endcase
    end

    // Next state: register writes first, then hardware updates so they take precedence
    always_comb begin
        ctl_d    = ctl_q;
        primsk_d = primsk_q;
        inserv_d = inserv_q;
        reqst_d  = reqst_q;
        vec_d    = vec_q;
        eoi_sel  = type_src(wdat[4:0]);

        if (lo_wr && (wb_adr_i == ADR_MASK)) begin
            for (int i = 0; i < NSRC; i++) ctl_d[i][CTL_MSK] = wdat[i];
        end
        if (lo_wr && ctl_hit) ctl_d[ctl_idx] = wdat[CTL_W-1:0];
        if (lo_wr && (wb_adr_i == ADR_PRIMSK)) primsk_d = wdat[2:0];
        if (lo_wr && (wb_adr_i == ADR_INSERV)) inserv_d = wdat[NSRC-1:0];

        // EOI clears before the acknowledge sets, so a same-bit set survives
        if (wr && (wb_adr_i == ADR_EOI)) begin
            if (wdat[15]) begin
                if (isr_vld) inserv_d[isr_idx] = 1'b0;
            end else if (eoi_sel.vld) begin
                inserv_d[eoi_sel.idx] = 1'b0;
            end
        end
        if (take) inserv_d[win_idx] = 1'b1;

        // Edge sources: a new edge beats the acknowledge clear; level sources track the pin
        for (int i = 0; i < NSRC; i++) begin
            if (ltm[i]) begin
                reqst_d[i] = sync2_q[i];
            end else begin
                if (take && (win_idx == 3'(i))) reqst_d[i] = 1'b0;
                if (rise[i]) reqst_d[i] = 1'b1;
            end
        end

        if (inta_edge) vec_d = win_vld ? {3'b0, win_type} : SPUR_VEC;
    end

    assign intr_d = win_vld & ~(inta_edge | poll_rd);
    assign ack_d  = wb_req;
    assign dat_d  = rd ? rdata : 16'h0000;

    // Input synchronisers plus the delay stage used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reqst_q  <= '0;
            inserv_q <= '0;
            ctl_q    <= {NSRC{CTL_RST}};
            primsk_q <= PRIMSK_RST;
            inta_q   <= 1'b0;
            intr_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            vec_q    <= '0;
        end else begin
            reqst_q  <= reqst_d;
            inserv_q <= inserv_d;
            ctl_q    <= ctl_d;
            primsk_q <= primsk_d;
            inta_q   <= inta_i;
            intr_q   <= intr_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            vec_q    <= vec_d;
        end
    end

    assign intr_o   = intr_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign vec_o    = vec_q;

endmodule
